// File: rtl/chal_list_expand_if.sv
// Start/result and hash-engine handshake signals for chal_list_expand.
// The slave modport is the expander; the master modport is the requester
// that also plays the role of the external hash engine.
interface chal_list_expand_if #(
  parameter int unsigned DIGEST_W = 256,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned T        = 4
) ();

  logic                start;
  logic [DIGEST_W-1:0] seed_digest;
  logic                busy;
  logic                done;
  logic                error;
  logic [T*IDX_W-1:0]  lc;
  logic [T*IDX_W-1:0]  lp;
  logic [7:0]          rehash_count;
  logic                hash_req;
  logic [DIGEST_W-1:0] hash_msg;
  logic                hash_ack;
  logic [DIGEST_W-1:0] hash_digest;

  modport master (
    output start,
    output seed_digest,
    output hash_ack,
    output hash_digest,
    input  busy,
    input  done,
    input  error,
    input  lc,
    input  lp,
    input  rehash_count,
    input  hash_req,
    input  hash_msg
  );

  modport slave (
    input  start,
    input  seed_digest,
    input  hash_ack,
    input  hash_digest,
    output busy,
    output done,
    output error,
    output lc,
    output lp,
    output rehash_count,
    output hash_req,
    output hash_msg
  );

endinterface

// File: rtl/chal_list_expand.sv
// Challenge list expander: turns a seed digest into T distinct circuit
// indices (Lc, each < NC) and T party indices (Lp, each < NP), consuming
// IDX_W-bit chunks MSB-first, one per cycle. An external hash engine is
// asked for a fresh digest whenever the current one runs out of chunks and
// once between the two lists; too many rehashes end the run in an error.
module chal_list_expand #(
  parameter int unsigned DIGEST_W   = 256,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned T          = 4,
  parameter int unsigned NC         = 8,
  parameter int unsigned NP         = 16,
  parameter int unsigned MAX_REHASH = 16
) (
  input logic               clk,
  input logic               reset,
  chal_list_expand_if.slave bus
);

  // Whole chunks per digest; residual low bits are never consumed.
  localparam int unsigned CH   = DIGEST_W / IDX_W;
  localparam int unsigned CntW = $clog2(CH + 1);
  localparam int unsigned KW   = $clog2(T + 1);
  localparam int unsigned LW   = T * IDX_W;

  typedef enum logic [2:0] {
    StIdle,
    StLcScan,
    StLpScan,
    StHreq,
    StDone,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic [CntW-1:0]     chunk_cnt_q, chunk_cnt_d;
  logic [KW-1:0]       k_q, k_d;
  logic [LW-1:0]       lc_q, lc_d;
  logic [LW-1:0]       lp_q, lp_d;
  logic [7:0]          rehash_q, rehash_d;
  // Scan state to resume after the pending rehash: 1 = Lp, 0 = Lc.
  logic                to_lp_q, to_lp_d;

  logic [IDX_W-1:0] chunk;
  logic             lc_dup;
  logic             lc_ok;
  logic             lp_ok;
  logic             last_entry;
  logic             last_chunk;
  logic             limit_hit;
  logic             hreq_go;
  logic             hreq_lp;

  assign chunk      = digest_q[DIGEST_W-1 -: IDX_W];
  assign last_entry = (k_q == KW'(T - 1));
  assign last_chunk = (chunk_cnt_q == CntW'(CH - 1));
  assign limit_hit  = (rehash_q == 8'(MAX_REHASH));
  assign lc_ok      = (32'(chunk) < NC) && !lc_dup;
  assign lp_ok      = (32'(chunk) < NP);

  // Duplicate search over the Lc entries filled so far; empty slots never match.
  always_comb begin
    lc_dup = 1'b0;
    for (int unsigned i = 0; i < T; i++) begin
      if ((KW'(i) < k_q) && (lc_q[(T-1-i)*IDX_W +: IDX_W] == chunk)) begin
        lc_dup = 1'b1;
      end
    end
  end

  // Next-state logic: scanning, list fill, rehash handshake and abort handling.
  always_comb begin
    state_d     = state_q;
    digest_d    = digest_q;
    chunk_cnt_d = chunk_cnt_q;
    k_d         = k_q;
    lc_d        = lc_q;
    lp_d        = lp_q;
    rehash_d    = rehash_q;
    to_lp_d     = to_lp_q;
    hreq_go     = 1'b0;
    hreq_lp     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          digest_d    = bus.seed_digest;
          chunk_cnt_d = '0;
          k_d         = '0;
          lc_d        = '0;
          lp_d        = '0;
          rehash_d    = '0;
          to_lp_d     = 1'b0;
          state_d     = StLcScan;
        end
      end

      StLcScan: begin
        if (!bus.start) begin
          state_d = StIdle;
        end else begin
          digest_d    = digest_q << IDX_W;
          chunk_cnt_d = chunk_cnt_q + 1'b1;
          if (lc_ok) begin
            for (int unsigned i = 0; i < T; i++) begin
              if (KW'(i) == k_q) begin
                lc_d[(T-1-i)*IDX_W +: IDX_W] = chunk;
              end
            end
            k_d = k_q + 1'b1;
          end
          // Completing the list wins over running out of chunks.
          if (lc_ok && last_entry) begin
            k_d     = '0;
            hreq_go = 1'b1;
            hreq_lp = 1'b1;
          end else if (last_chunk) begin
            hreq_go = 1'b1;
            hreq_lp = 1'b0;
          end
        end
      end

      StLpScan: begin
        if (!bus.start) begin
          state_d = StIdle;
        end else begin
          digest_d    = digest_q << IDX_W;
          chunk_cnt_d = chunk_cnt_q + 1'b1;
          if (lp_ok) begin
            for (int unsigned i = 0; i < T; i++) begin
              if (KW'(i) == k_q) begin
                lp_d[(T-1-i)*IDX_W +: IDX_W] = chunk;
              end
            end
            k_d = k_q + 1'b1;
          end
          if (lp_ok && last_entry) begin
            k_d     = '0;
            state_d = StDone;
          end else if (last_chunk) begin
            hreq_go = 1'b1;
            hreq_lp = 1'b1;
          end
        end
      end

      StHreq: begin
        if (!bus.start) begin
          state_d = StIdle;
        end else if (bus.hash_ack) begin
          digest_d    = bus.hash_digest;
          chunk_cnt_d = '0;
          state_d     = to_lp_q ? StLpScan : StLcScan;
        end
      end

      StDone, StErr: begin
        if (!bus.start) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // The rehash limit is checked as HREQ is entered, so hash_req is a clean
    // state decode and is never raised once the budget is spent.
    if (hreq_go) begin
      if (limit_hit) begin
        state_d = StErr;
      end else begin
        state_d  = StHreq;
        to_lp_d  = hreq_lp;
        rehash_d = rehash_q + 8'd1;
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      digest_q    <= '0;
      chunk_cnt_q <= '0;
      k_q         <= '0;
      lc_q        <= '0;
      lp_q        <= '0;
      rehash_q    <= '0;
      to_lp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      digest_q    <= digest_d;
      chunk_cnt_q <= chunk_cnt_d;
      k_q         <= k_d;
      lc_q        <= lc_d;
      lp_q        <= lp_d;
      rehash_q    <= rehash_d;
      to_lp_q     <= to_lp_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  always_comb begin
    bus.busy         = (state_q == StLcScan) || (state_q == StLpScan) || (state_q == StHreq);
    bus.done         = (state_q == StDone);
    bus.error        = (state_q == StErr);
    bus.hash_req     = (state_q == StHreq);
    // Digest does not shift while in HREQ, so the message is stable until ack.
    bus.hash_msg     = (state_q == StHreq) ? digest_q : '0;
    bus.lc           = lc_q;
    bus.lp           = lp_q;
    bus.rehash_count = rehash_q;
  end

endmodule
